// File: rtl/bsg_cache_nb_pkg.sv
// Shared types and helpers for the non-blocking cache DMA responder.
package bsg_cache_nb_pkg;

    localparam int unsigned dma_addr_width_gp      = 32;
    localparam int unsigned dma_block_size_words_gp = 16;
    localparam int unsigned dma_mshr_els_gp        = 4;

    // Index width that stays at least one bit wide for single-entry structures.
    function automatic int unsigned bsg_cache_nb_lg(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flat width of a DMA packet: {write_not_read, addr, mask, mshr_id}.
    function automatic int unsigned bsg_cache_nb_dma_pkt_width(
        input int unsigned addr_width,
        input int unsigned block_size_in_words,
        input int unsigned mshr_els
    );
        return 1 + addr_width + block_size_in_words + bsg_cache_nb_lg(mshr_els);
    endfunction

    // DMA packet payload at the default cache geometry.
    typedef struct packed {
        logic                                          write_not_read;
        logic [dma_addr_width_gp-1:0]                  addr;
        logic [dma_block_size_words_gp-1:0]            mask;
        logic [$clog2(dma_mshr_els_gp)-1:0]            mshr_id;
    } bsg_cache_nb_dma_pkt_s;

    typedef enum logic [1:0] {
        e_dma_resp_idle  = 2'd0,
        e_dma_resp_read  = 2'd1,
        e_dma_resp_write = 2'd2
    } bsg_cache_nb_dma_resp_state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write enables.
module bsg_mem_1rw_sync_mask_write_byte
    import bsg_cache_nb_pkg::*;
#(
    parameter int unsigned els_p        = 4096,
    parameter int unsigned data_width_p = 128
)(
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  v_i,
    input  logic                                  w_i,
    input  logic [bsg_cache_nb_lg(els_p)-1:0]     addr_i,
    input  logic [data_width_p-1:0]               data_i,
    input  logic [data_width_p/8-1:0]             write_mask_i,
    output logic [data_width_p-1:0]               data_o
);

    localparam int unsigned bytes_lp = data_width_p / 8;

    logic [data_width_p-1:0] mem_q [els_p];
    logic [data_width_p-1:0] data_q;

    // Byte-masked write; array contents are never touched by reset.
    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int b = 0; b < int'(bytes_lp); b++) begin
                if (write_mask_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read data register: updates only on a read, so it holds otherwise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (v_i & ~w_i) begin
            data_q <= mem_q[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_cache_nb_dma_responder.sv
// Memory-side target for the non-blocking cache DMA interface, backed by an SRAM.
module bsg_cache_nb_dma_responder
    import bsg_cache_nb_pkg::*;
#(
    parameter int unsigned addr_width_p          = 32,
    parameter int unsigned word_width_p          = 32,
    parameter int unsigned dma_data_width_p      = 128,
    parameter int unsigned block_size_in_words_p = 16,
    parameter int unsigned mshr_els_p            = 4,
    parameter int unsigned mem_els_p             = 4096
)(
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [bsg_cache_nb_dma_pkt_width(addr_width_p, block_size_in_words_p, mshr_els_p)-1:0] dma_pkt_i,
    input  logic                                  dma_pkt_v_i,
    output logic                                  dma_pkt_yumi_o,
    output logic [dma_data_width_p-1:0]           dma_data_o,
    output logic [bsg_cache_nb_lg(mshr_els_p)-1:0] dma_mshr_id_o,
    output logic                                  dma_data_v_o,
    input  logic                                  dma_data_ready_i,
    input  logic [dma_data_width_p-1:0]           dma_data_i,
    input  logic                                  dma_data_v_i,
    output logic                                  dma_data_yumi_o,
    output logic                                  busy_o
);

    localparam int unsigned lg_mshr_lp         = bsg_cache_nb_lg(mshr_els_p);
    localparam int unsigned bursts_lp          = block_size_in_words_p * word_width_p / dma_data_width_p;
    localparam int unsigned words_per_burst_lp = dma_data_width_p / word_width_p;
    localparam int unsigned bytes_per_word_lp  = word_width_p / 8;
    localparam int unsigned byte_offset_lp     = $clog2(dma_data_width_p / 8);
    localparam int unsigned mem_addr_width_lp  = bsg_cache_nb_lg(mem_els_p);
    localparam int unsigned cnt_width_lp       = $clog2(bursts_lp + 1);
    localparam int unsigned byte_mask_width_lp = dma_data_width_p / 8;

    localparam logic [1:0] state_idle_lp  = 2'(e_dma_resp_idle);
    localparam logic [1:0] state_read_lp  = 2'(e_dma_resp_read);
    localparam logic [1:0] state_write_lp = 2'(e_dma_resp_write);

    // Packet fields, MSB first.
    logic                             pkt_write_not_read;
    logic [addr_width_p-1:0]          pkt_addr;
    logic [block_size_in_words_p-1:0] pkt_mask;
    logic [lg_mshr_lp-1:0]            pkt_mshr_id;

    assign {pkt_write_not_read, pkt_addr, pkt_mask, pkt_mshr_id} = dma_pkt_i;

    logic [1:0]                       state_q, state_d;
    logic [mem_addr_width_lp-1:0]     blk_base_q, blk_base_d;
    logic [block_size_in_words_p-1:0] mask_q, mask_d;
    logic [lg_mshr_lp-1:0]            id_q, id_d;
    logic [cnt_width_lp-1:0]          issued_q, issued_d;
    logic [cnt_width_lp-1:0]          done_q, done_d;
    logic                             data_v_q, data_v_d;
    logic [lg_mshr_lp-1:0]            mshr_out_q, mshr_out_d;

    logic                             pkt_yumi;
    logic                             data_yumi;
    logic                             sram_v;
    logic                             sram_w;
    logic [mem_addr_width_lp-1:0]     sram_addr;
    logic [byte_mask_width_lp-1:0]    sram_byte_mask;
    logic [dma_data_width_p-1:0]      sram_data;
    logic [words_per_burst_lp-1:0]    word_mask;
    logic                             drain;

    assign drain     = data_v_q & dma_data_ready_i;
    assign sram_addr = blk_base_q + mem_addr_width_lp'(issued_q);
    assign word_mask = words_per_burst_lp'(mask_q >> (32'(issued_q) * words_per_burst_lp));

    // Next-state, counters and SRAM control.
    always_comb begin
        state_d        = state_q;
        blk_base_d     = blk_base_q;
        mask_d         = mask_q;
        id_d           = id_q;
        issued_d       = issued_q;
        done_d         = done_q;
        data_v_d       = data_v_q;
        mshr_out_d     = mshr_out_q;
        pkt_yumi       = 1'b0;
        data_yumi      = 1'b0;
        sram_v         = 1'b0;
        sram_w         = 1'b0;
        sram_byte_mask = '0;

        if (drain) begin
            data_v_d = 1'b0;
        end

        case (state_q)
            state_idle_lp: begin
                pkt_yumi = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    blk_base_d = mem_addr_width_lp'(pkt_addr >> byte_offset_lp)
                               & ~mem_addr_width_lp'(bursts_lp - 1);
                    mask_d     = pkt_mask;
                    id_d       = pkt_mshr_id;
                    issued_d   = '0;
                    done_d     = '0;
                    state_d    = pkt_write_not_read ? state_write_lp : state_read_lp;
                end
            end
            state_read_lp: begin
                if ((~data_v_q | drain) && (issued_q < cnt_width_lp'(bursts_lp))) begin
                    sram_v     = 1'b1;
                    issued_d   = issued_q + 1'b1;
                    data_v_d   = 1'b1;
                    mshr_out_d = id_q;
                end
                if (drain) begin
                    done_d = done_q + 1'b1;
                    if (done_q == cnt_width_lp'(bursts_lp - 1)) begin
                        state_d = state_idle_lp;
                    end
                end
            end
            state_write_lp: begin
                data_yumi = dma_data_v_i;
                if (dma_data_v_i) begin
                    sram_v   = 1'b1;
                    sram_w   = 1'b1;
                    issued_d = issued_q + 1'b1;
                    for (int w = 0; w < int'(words_per_burst_lp); w++) begin
                        sram_byte_mask[w*bytes_per_word_lp +: bytes_per_word_lp] =
                            {bytes_per_word_lp{word_mask[w]}};
                    end
                    if (issued_q == cnt_width_lp'(bursts_lp - 1)) begin
                        state_d = state_idle_lp;
                    end
                end
            end
            default: begin
                state_d = state_idle_lp;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= state_idle_lp;
            blk_base_q <= '0;
            mask_q     <= '0;
            id_q       <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            data_v_q   <= 1'b0;
            mshr_out_q <= '0;
        end else begin
            state_q    <= state_d;
            blk_base_q <= blk_base_d;
            mask_q     <= mask_d;
            id_q       <= id_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            data_v_q   <= data_v_d;
            mshr_out_q <= mshr_out_d;
        end
    end

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (dma_data_width_p)
    ) mem (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (sram_v & ~reset_i),
        .w_i          (sram_w),
        .addr_i       (sram_addr),
        .data_i       (dma_data_i),
        .write_mask_i (sram_byte_mask),
        .data_o       (sram_data)
    );

    assign dma_pkt_yumi_o  = pkt_yumi & ~reset_i;
    assign dma_data_yumi_o = data_yumi & ~reset_i;
    assign dma_data_o      = sram_data;
    assign dma_mshr_id_o   = mshr_out_q;
    assign dma_data_v_o    = data_v_q;
    assign busy_o          = (state_q != state_idle_lp);

endmodule

// File: tb/tb_bsg_cache_nb_dma_responder.sv
// Self-checking bench for bsg_cache_nb_dma_responder against a block-level memory model.
module tb_bsg_cache_nb_dma_responder;
    import bsg_cache_nb_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_i;
    bsg_cache_nb_dma_pkt_s pkt;
    logic                  pkt_v;
    logic                  pkt_yumi;
    logic [127:0]          data_o;
    logic [1:0]            mshr_id_o;
    logic                  data_v_o;
    logic                  data_ready;
    logic [127:0]          data_i;
    logic                  data_v_i;
    logic                  data_yumi;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [127:0] model_mem [4096];
    bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bsg_cache_nb_dma_responder dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .dma_pkt_i        (pkt),
        .dma_pkt_v_i      (pkt_v),
        .dma_pkt_yumi_o   (pkt_yumi),
        .dma_data_o       (data_o),
        .dma_mshr_id_o    (mshr_id_o),
        .dma_data_v_o     (data_v_o),
        .dma_data_ready_i (data_ready),
        .dma_data_i       (data_i),
        .dma_data_v_i     (data_v_i),
        .dma_data_yumi_o  (data_yumi),
        .busy_o           (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Memory index of burst k of the block containing byte address a (wraps at depth).
    function automatic int unsigned midx(input logic [31:0] a, input int k);
        return ((32'(a / 16) / 4) * 4 + 32'(k)) % 4096;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (pkt_yumi) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [15:0] mask, input logic [1:0] id,
                            input logic [127:0] d [4], input bit gaps);
        bit ok;
        pkt      = '{write_not_read: 1'b1, addr: addr, mask: mask, mshr_id: id};
        pkt_v    = 1'b1;
        data_v_i = 1'b1;
        data_i   = d[0];
        wait_accept(ok);
        if (!ok) begin
            check_eq("wr_accept_timeout", 128'(pkt_yumi), 128'(1));
            pkt_v = 1'b0; data_v_i = 1'b0;
            return;
        end
        check_eq("wr_early_yumi", 128'(data_yumi), 128'(0));
        step();
        pkt_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                data_v_i = 1'b0;
                #1;
                check_eq("wr_gap_yumi", 128'(data_yumi), 128'(0));
                step();
            end
            data_v_i = 1'b1;
            data_i   = d[k];
            #1;
            check_eq("wr_yumi", 128'(data_yumi), 128'(1));
            step();
        end
        data_v_i = 1'b0;
        check_eq("wr_done_busy", 128'(busy), 128'(0));
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 4; w++) begin
                if (mask[k*4 + w]) model_mem[midx(addr, k)][w*32 +: 32] = d[k][w*32 +: 32];
            end
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic do_read(input logic [31:0] addr, input logic [1:0] id, input int mode,
                           input bit hold_next, input bsg_cache_nb_dma_pkt_s nxt);
        bit ok;
        int acc, first, got, t;
        logic rdy;
        pkt   = '{write_not_read: 1'b0, addr: addr, mask: 16'h0, mshr_id: id};
        pkt_v = 1'b1;
        wait_accept(ok);
        if (!ok) begin
            check_eq("rd_accept_timeout", 128'(pkt_yumi), 128'(1));
            pkt_v = 1'b0;
            return;
        end
        acc = cyc;
        step();
        if (hold_next) begin
            pkt = nxt;
        end else begin
            pkt_v = 1'b0;
        end
        got = 0; first = -1; t = 0;
        while (got < 4 && t < 100) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = pat[t % 4];
            else                rdy = 1'($urandom_range(0, 1));
            data_ready = rdy;
            #1;
            if (hold_next) check_eq("b2b_no_early_yumi", 128'(pkt_yumi), 128'(0));
            if (data_v_o) begin
                if (first < 0) begin
                    first = cyc;
                    if (mode == 0) check_eq("rd_latency", 128'(first - acc), 128'(2));
                end
                check_eq("rd_data", data_o, model_mem[midx(addr, got)]);
                check_eq("rd_id", 128'(mshr_id_o), 128'(id));
                if (rdy) got++;
            end else if (mode == 0 && first >= 0) begin
                check_eq("rd_bubble", 128'(data_v_o), 128'(1));
            end
            step();
            t++;
        end
        if (got < 4) check_eq("rd_timeout", 128'(got), 128'(4));
        data_ready = 1'b0;
        check_eq("rd_done_v", 128'(data_v_o), 128'(0));
        check_eq("rd_done_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [127:0] d [4];
        logic [127:0] ones [4];
        bsg_cache_nb_dma_pkt_s nxt, none;
        int unsigned blks [8];
        bit ok;

        none       = '0;
        reset_i    = 1'b1;
        pkt        = '0;
        pkt_v      = 1'b1;
        data_ready = 1'b0;
        data_i     = '0;
        data_v_i   = 1'b1;
        step(); step(); step();
        check_eq("rst_pkt_yumi", 128'(pkt_yumi), 128'(0));
        check_eq("rst_data_v", 128'(data_v_o), 128'(0));
        check_eq("rst_data_yumi", 128'(data_yumi), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        pkt_v = 1'b0; data_v_i = 1'b0;
        reset_i = 1'b0;
        step();

        // Full write then read back with a different tag.
        for (int k = 0; k < 4; k++) d[k] = {4{32'hD000_0000 + 32'(k)}};
        do_write(32'h100, 16'hFFFF, 2'd2, d, 1'b0);
        do_read(32'h100, 2'd1, 0, 1'b0, none);

        // Partial mask touches burst 0 only.
        for (int k = 0; k < 4; k++) ones[k] = {128{1'b1}};
        do_write(32'h100, 16'h000F, 2'd0, ones, 1'b0);
        check_eq("partial_model_b1", model_mem[midx(32'h100, 1)], d[1]);
        do_read(32'h100, 2'd1, 0, 1'b0, none);

        // Stalled reader.
        do_read(32'h100, 2'd2, 1, 1'b0, none);

        // Back-to-back reads with the second packet held pending.
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
        do_write(32'h0, 16'hFFFF, 2'd0, d, 1'b0);
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
        do_write(32'h40, 16'hFFFF, 2'd0, d, 1'b0);
        nxt = '{write_not_read: 1'b0, addr: 32'h40, mask: 16'h0, mshr_id: 2'd3};
        do_read(32'h0, 2'd0, 0, 1'b1, nxt);
        do_read(32'h40, 2'd3, 0, 1'b0, none);

        // Out-of-range address wraps onto the same SRAM row.
        do_read(32'h0001_0100, 2'd1, 0, 1'b0, none);

        // All-zero mask leaves memory intact.
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
        do_write(32'h100, 16'h0000, 2'd1, d, 1'b1);
        do_read(32'h100, 2'd0, 2, 1'b0, none);

        // Reset during the second write burst.
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
        pkt      = '{write_not_read: 1'b1, addr: 32'h200, mask: 16'hFFFF, mshr_id: 2'd1};
        pkt_v    = 1'b1;
        data_v_i = 1'b1;
        data_i   = d[0];
        wait_accept(ok);
        check_eq("rstw_accept", 128'(ok), 128'(1));
        step();
        pkt_v = 1'b0;
        #1;
        check_eq("rstw_yumi0", 128'(data_yumi), 128'(1));
        step();
        data_i  = d[1];
        reset_i = 1'b1;
        step();
        reset_i  = 1'b0;
        data_v_i = 1'b1;
        #1;
        check_eq("rstw_busy", 128'(busy), 128'(0));
        check_eq("rstw_data_v", 128'(data_v_o), 128'(0));
        check_eq("rstw_data_yumi", 128'(data_yumi), 128'(0));
        check_eq("rstw_pkt_yumi", 128'(pkt_yumi), 128'(0));
        check_eq("rstw_data_o", data_o, 128'(0));
        check_eq("rstw_mshr_id", 128'(mshr_id_o), 128'(0));
        data_v_i = 1'b0;
        step();
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
        do_write(32'h200, 16'hFFFF, 2'd3, d, 1'b0);
        do_read(32'h200, 2'd3, 0, 1'b0, none);

        // Randomized traffic over a small pool of blocks with aliasing upper bits.
        for (int b = 0; b < 8; b++) begin
            blks[b] = $urandom_range(0, 1023);
            for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
            do_write(32'(blks[b] * 64), 16'hFFFF, 2'(b), d, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_0000) | 32'(blks[$urandom_range(0, 7)] * 64) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom, $urandom, $urandom};
                do_write(a, 16'($urandom), 2'($urandom), d, 1'b1);
            end else begin
                do_read(a, 2'($urandom), int'($urandom_range(0, 2)), 1'b0, none);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
